// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP datapath constants and helpers
package dsp_pkg;

    // Upper bound on the elastic pipe depth.
    localparam int DSP_MAX_PIPE_DEPTH = 16;

    // Reset style selectors used by the legacy single optional stage.
    localparam string RSTTYPE_SYNC  = "SYNC";
    localparam string RSTTYPE_ASYNC = "ASYNC";

    // $clog2 that never returns less than 1, so count ports stay at least 1 bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// rtl/dsp_pipe_stage.sv - one valid-tagged data register of the elastic pipe
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   adv       - stage advances this edge (loads upstream valid/data)
//   clr       - clears the valid bit this edge (flush), data holds
//   up_valid  - upstream valid
//   up_data   - upstream data
//   vld       - stage valid
//   data      - stage data
module dsp_pipe_stage #(
    parameter int               WIDTH   = 18,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= RST_VAL;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (adv) begin
            vld <= up_valid;
            // Data only loads behind a valid word, so empty slots never pick up X.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dsp_elastic_pipe.sv
// rtl/dsp_elastic_pipe.sv - elastic ready/valid register chain for the DSP datapath
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   ce         - global clock enable, 0 freezes every stage
//   flush      - synchronous clear of all valid bits (overrides ce)
//   in_data    - upstream data
//   in_valid   - upstream valid
//   in_ready   - word accepted this cycle
//   out_data   - last-stage data
//   out_valid  - last-stage valid
//   out_ready  - downstream accepts out_data this cycle
//   count      - number of valid stages
module dsp_elastic_pipe
    import dsp_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ce,
    input  logic                               flush,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [clog2_min1(DEPTH+1)-1:0]     count
);

    localparam int CW = clog2_min1(DEPTH + 1);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Pure wire: no state, so clock, reset and flush have nothing to act on.
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, flush};

            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign in_ready  = out_ready & ce;
            assign count     = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0] svld;
            logic [WIDTH-1:0] sdata [DEPTH];
            logic [DEPTH-1:0] adv;
            logic             en;
            logic             room;
            logic [CW-1:0]    pop;

            assign en = ce & ~flush;

            // Ready chain: stage i moves when it is empty or everything ahead of it moves.
            // Since en is common to every term it factors out, leaving a running
            // "hole at or after i, or the output drains" term built from the tail back.
            always_comb begin
                adv  = '0;
                room = out_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    room   = room | ~svld[i];
                    adv[i] = en & room;
                end
            end

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                if (i == 0) begin : g_first
                    dsp_pipe_stage #(
                        .WIDTH   (WIDTH),
                        .RST_VAL (RST_VAL)
                    ) u_stage (
                        .clk      (clk),
                        .rst      (rst),
                        .adv      (adv[i]),
                        .clr      (flush),
                        .up_valid (in_valid),
                        .up_data  (in_data),
                        .vld      (svld[i]),
                        .data     (sdata[i])
                    );
                end else begin : g_next
                    dsp_pipe_stage #(
                        .WIDTH   (WIDTH),
                        .RST_VAL (RST_VAL)
                    ) u_stage (
                        .clk      (clk),
                        .rst      (rst),
                        .adv      (adv[i]),
                        .clr      (flush),
                        .up_valid (svld[i-1]),
                        .up_data  (sdata[i-1]),
                        .vld      (svld[i]),
                        .data     (sdata[i])
                    );
                end
            end

            // Occupancy straight from the valid flops; saturates at DEPTH by construction.
            always_comb begin
                pop = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    pop = pop + CW'(svld[i]);
                end
            end

            assign in_ready  = adv[0];
            assign out_data  = sdata[DEPTH-1];
            assign out_valid = svld[DEPTH-1];
            assign count     = pop;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_elastic_pipe.sv
// tb/tb_dsp_elastic_pipe.sv - self-checking bench for dsp_elastic_pipe
module tb_dsp_elastic_pipe;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        flush;
    logic [17:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        ir3, ov3;
    logic [17:0] od3;
    logic [1:0]  cnt3;
    logic        ir_rv, ov_rv;
    logic [17:0] od_rv;
    logic [1:0]  cnt_rv;
    logic        ir0, ov0;
    logic [17:0] od0;
    logic [0:0]  cnt0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_elastic_pipe #(.WIDTH(18), .DEPTH(3), .RST_VAL(18'h0)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir3),
        .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .count(cnt3)
    );

    dsp_elastic_pipe #(.WIDTH(18), .DEPTH(3), .RST_VAL(18'h12345)) u_rv (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_rv),
        .out_data(od_rv), .out_valid(ov_rv), .out_ready(out_ready), .count(cnt_rv)
    );

    dsp_elastic_pipe #(.WIDTH(18), .DEPTH(0), .RST_VAL(18'h0)) u_byp (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .count(cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: an ordered list of words (oldest first) with their slot positions.
    // Each enabled edge the oldest word leaves if it sits in the last slot and
    // downstream is ready; every other word steps one slot forward unless the
    // word ahead of it blocks; an accepted input lands in slot 0.
    int          mn;
    logic [17:0] md [16];
    int          mp [16];
    logic [17:0] m_last;
    bit          m_acc;
    int          m_lim;
    int          m_np;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mn     = 0;
            m_last = 18'h0;
        end else if (flush) begin
            mn = 0;
        end else if (ce) begin
            m_acc = (mn < D) || out_ready;
            if (out_ready && mn > 0 && mp[0] == D - 1) begin
                for (int i = 0; i < mn - 1; i++) begin
                    md[i] = md[i+1];
                    mp[i] = mp[i+1];
                end
                mn--;
            end
            m_lim = D - 1;
            for (int i = 0; i < mn; i++) begin
                m_np = mp[i] + 1;
                if (m_np > m_lim) m_np = m_lim;
                mp[i] = m_np;
                if (m_np == D - 1) m_last = md[i];
                m_lim = m_np - 1;
            end
            if (m_acc && in_valid) begin
                md[mn] = in_data;
                mp[mn] = 0;
                mn++;
            end
        end
    end

    // Observed output transfers and peak occupancy.
    logic [17:0] obs [$];
    int          peak = 0;

    always @(negedge clk) begin
        logic exp_ir, exp_ov;
        exp_ir = ce && !flush && ((mn < D) || out_ready);
        exp_ov = (mn > 0) && (mp[0] == D - 1);
        chk("in_ready", {31'd0, ir3}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, ov3}, {31'd0, exp_ov});
        chk("out_data", {14'd0, od3}, {14'd0, m_last});
        chk("count", {30'd0, cnt3}, mn);
        chk("rv_in_ready", {31'd0, ir_rv}, {31'd0, exp_ir});
        chk("rv_out_valid", {31'd0, ov_rv}, {31'd0, exp_ov});
        chk("rv_count", {30'd0, cnt_rv}, mn);
        chk("byp_out_data", {14'd0, od0}, {14'd0, in_data});
        chk("byp_out_valid", {31'd0, ov0}, {31'd0, in_valid});
        chk("byp_in_ready", {31'd0, ir0}, {31'd0, out_ready & ce});
        chk("byp_count", {31'd0, cnt0}, 32'd0);
        if (!rst && ce && ov3 && out_ready) obs.push_back(od3);
        if (int'(cnt3) > peak) peak = int'(cnt3);
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; flush = 1'b0;
        in_data = 18'h0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, ov3}, 32'd0);
        chk("rst_out_data", {14'd0, od3}, 32'h0);
        chk("rst_count", {30'd0, cnt3}, 32'd0);
        chk("rst_in_ready", {31'd0, ir3}, 32'd1);
        chk("rst_rv_out_data", {14'd0, od_rv}, 32'h12345);
        cyc(1);
        rst = 1'b0;

        // 1: streaming
        obs.delete();
        peak = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(k + 1);
            cyc(1);
            if (k == 1) chk("t1_not_yet_valid", {31'd0, ov3}, 32'd0);
            if (k == 2) begin
                chk("t1_first_valid", {31'd0, ov3}, 32'd1);
                chk("t1_first_data", {14'd0, od3}, 32'h1);
            end
        end
        in_valid = 1'b0;
        cyc(5);
        chk("t1_obs_size", obs.size(), 32'd5);
        for (int k = 0; k < 5; k++) chk("t1_obs", {14'd0, obs[k]}, k + 1);
        chk("t1_peak", peak, 32'd3);

        // 2: backpressure and bubble collapse
        obs.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 18'h0AAAA;
        cyc(1);
        in_valid = 1'b0;
        cyc(2);
        in_valid = 1'b1; in_data = 18'h15555;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        chk("t2_count2", {30'd0, cnt3}, 32'd2);
        chk("t2_ready_open", {31'd0, ir3}, 32'd1);
        chk("t2_head", {14'd0, od3}, 32'h0AAAA);
        in_valid = 1'b1; in_data = 18'h3FFFF;
        #1;
        chk("t2_ready_last", {31'd0, ir3}, 32'd1);
        cyc(1);
        chk("t2_count3", {30'd0, cnt3}, 32'd3);
        chk("t2_ready_full", {31'd0, ir3}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(4);
        chk("t2_obs_size", obs.size(), 32'd3);
        chk("t2_obs0", {14'd0, obs[0]}, 32'h0AAAA);
        chk("t2_obs1", {14'd0, obs[1]}, 32'h15555);
        chk("t2_obs2", {14'd0, obs[2]}, 32'h3FFFF);

        // 3: full push/pop
        obs.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(32'h10 + k);
            cyc(1);
        end
        chk("t3_full", {30'd0, cnt3}, 32'd3);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(32'h20 + k);
            out_ready = 1'b1;
            #1;
            chk("t3_ready", {31'd0, ir3}, 32'd1);
            chk("t3_count", {30'd0, cnt3}, 32'd3);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(5);
        chk("t3_obs_size", obs.size(), 32'd13);
        for (int k = 0; k < 3; k++) chk("t3_obs_old", {14'd0, obs[k]}, 32'h10 + k);
        for (int k = 0; k < 10; k++) chk("t3_obs_new", {14'd0, obs[3+k]}, 32'h20 + k);

        // 4: flush
        obs.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(32'h31 + k);
            cyc(1);
        end
        in_data = 18'h99;
        flush = 1'b1;
        #1;
        chk("t4_flush_ready", {31'd0, ir3}, 32'd0);
        cyc(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t4_count", {30'd0, cnt3}, 32'd0);
        chk("t4_out_valid", {31'd0, ov3}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(32'h41 + k);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(5);
        chk("t4_obs_size", obs.size(), 32'd2);
        chk("t4_obs0", {14'd0, obs[0]}, 32'h41);
        chk("t4_obs1", {14'd0, obs[1]}, 32'h42);

        // 5: clock enable freeze, then async reset mid-cycle
        obs.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(32'h51 + k);
            cyc(1);
        end
        ce = 1'b0;
        in_data = 18'h77;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_ready", {31'd0, ir3}, 32'd0);
            chk("t5_valid", {31'd0, ov3}, 32'd1);
            chk("t5_data", {14'd0, od3}, 32'h51);
            chk("t5_count", {30'd0, cnt3}, 32'd3);
            cyc(1);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cyc(1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, ov3}, 32'd0);
        chk("t5_rst_data", {14'd0, od3}, 32'h0);
        chk("t5_rst_count", {30'd0, cnt3}, 32'd0);
        chk("t5_rst_ready", {31'd0, ir3}, 32'd1);
        chk("t5_rst_rv_data", {14'd0, od_rv}, 32'h12345);
        cyc(1);
        rst = 1'b0;
        chk("t5_obs_size", obs.size(), 32'd0);

        // 6: DEPTH=0 bypass
        in_valid = 1'b1;
        in_data = 18'h2ABCD;
        out_ready = 1'b0;
        #1;
        chk("t6_data", {14'd0, od0}, 32'h2ABCD);
        chk("t6_valid", {31'd0, ov0}, 32'd1);
        chk("t6_ready_lo", {31'd0, ir0}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("t6_ready_hi", {31'd0, ir0}, 32'd1);
        cyc(1);
        in_valid = 1'b0;
        cyc(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_elastic_pipe.md
Name: dsp_elastic_pipe

Overview:
- Parametrised, valid-tagged pipeline register chain for the DSP datapath.
- Successor to the single optional stage: a configurable number of stages, ready/valid flow control, bubble collapsing, synchronous flush and an occupancy count.
- Sits between DSP sub-blocks (pre-adder, multiplier, post-adder) so the datapath can stall without losing data or throughput.
- DEPTH=0 degenerates to a pure combinational pass-through.

Parameters:
- WIDTH, 18, data bits per stage.
- DEPTH, 2, number of register stages (0..16); 0 = combinational bypass.
- RST_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  global clock enable; 0 freezes all stages.
- flush  in  1  synchronous clear of all valid bits.
- in_data  in  WIDTH  upstream data.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  WIDTH  last-stage data.
- out_valid  out  1  last-stage valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- count  out  $clog2(DEPTH+1)  number of valid stages (min 1 bit).

Behaviour:
- Stages are indexed 0..DEPTH-1. Stage 0 takes in_data; stage DEPTH-1 drives out_data and out_valid.
- Advance rule (combinational):
  - adv[DEPTH] = out_ready.
  - adv[i] = ce & ~flush & (~vld[i] | adv[i+1]).
  - in_ready = adv[0].
  - Ready is a combinational chain through all stages by design; no skid buffer.
- On a clock edge with adv[i]=1:
  - vld[i] takes the upstream valid (in_valid for i=0, vld[i-1] otherwise).
  - data[i] takes the upstream data only when that upstream valid=1; otherwise data[i] holds.
- A stage with adv[i]=0 holds both data and valid.
- Bubble collapsing: an empty stage always advances, even while the output is stalled, so gaps fill up behind a stall.
- Transfer definitions:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - An output word with out_ready=0 holds stable until it is accepted.
- Latency: DEPTH cycles from input transfer to out_valid when unstalled. Throughput: 1 word/cycle.
- ce=0: no state changes and in_ready=0, independent of out_ready. out_valid and out_data stay visible.
- flush=1 (sync, overrides ce):
  - All vld cleared on the next edge; data registers hold.
  - in_ready=0 that cycle, so in_valid in the same cycle is dropped.
  - An output transfer in the flush cycle is still counted by downstream; the word is not duplicated.
- count = popcount(vld), registered view, updated each edge. It saturates at DEPTH by construction.
- Full condition: count==DEPTH and out_ready=0 → in_ready=0.
- Simultaneous push and pop when full with out_ready=1: in_ready=1 and count is unchanged.
- rst=1 (async, any time, including mid-stall or mid-flush):
  - All vld=0, data=RST_VAL, count=0, out_valid=0, out_data=RST_VAL.
  - in_ready follows the combinational rule: 1 if ce & ~flush.
- DEPTH=0: out_data=in_data, out_valid=in_valid, in_ready=out_ready & ce, count=0, no registers; flush is ignored.
- No X propagation: data registers never load while the upstream valid is 0.

Decomposition:
- Shared package dsp_pkg:
  - Function clog2_min1 for the count width.
  - Constant DSP_MAX_PIPE_DEPTH=16.
  - Existing RSTTYPE string constants stay there for the legacy stage.
- One natural sub-module: dsp_pipe_stage (WIDTH, RST_VAL).
  - Holds one data register plus valid bit, with async rst.
  - Inputs: upstream valid/data, adv. Outputs: vld, data.
  - dsp_elastic_pipe generates DEPTH instances and the ready chain.

Test Plan (WIDTH=18, DEPTH=3, RST_VAL=0 unless noted):
1. Streaming: ce=1, out_ready=1, push 0x00001..0x00005 on consecutive cycles → out_valid rises 3 cycles after the first push, same values in order on 5 consecutive cycles, count peaks at 3.
2. Backpressure and bubble collapse: push 0x0AAAA, idle 2 cycles, push 0x15555 with out_ready=0 → both words compact to stages 2 and 1, count=2, in_ready stays 1. Push 0x3FFFF → count=3, then in_ready=0. Release out_ready → outputs 0x0AAAA, 0x15555, 0x3FFFF in order.
3. Full push/pop: pipe full, in_valid=1, out_ready=1 every cycle for 10 cycles → in_ready=1 each cycle, count constant 3, no loss or duplication.
4. Flush: pipe holds 3 words, assert flush for 1 cycle with in_valid=1 → next cycle count=0, out_valid=0, flush-cycle input not seen at the output, normal streaming afterwards.
5. ce and async reset: ce=0 for 4 cycles with data in flight → outputs frozen, in_ready=0. Assert rst between clock edges → out_valid=0 and out_data=0 immediately; with RST_VAL=0x12345, out_data=0x12345.
6. DEPTH=0 build: in_data=0x2ABCD, in_valid=1 → same-cycle out_data=0x2ABCD, out_valid=1, in_ready mirrors out_ready.
